// File: rtl/neuron_rate_decoder.sv
// Rate-code decoder: counts asserted spike_in samples over a WIN-cycle window
// and presents the saturated count on a valid/ready output.
`timescale 1ns/1ps
module neuron_rate_decoder #(
    parameter int WIN = 15,
    parameter int CW  = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          spike_in,
    input  logic          out_ready,
    output logic          out_valid,
    output logic [CW-1:0] rate,
    output logic          busy,
    output logic          overrun
);

    localparam int WCW = $clog2(WIN + 1);
    localparam logic [WCW-1:0] LAST    = WCW'(WIN - 1);
    localparam logic [CW:0]    SAT_MAX = {1'b0, {CW{1'b1}}};

    generate
        if (WIN < 1 || WIN > 255) begin : g_win_check
            $error("neuron_rate_decoder: WIN must be in 1..255");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t          state_reg;
    logic [CW-1:0]   acc_reg;
    logic [CW-1:0]   rate_reg;
    logic [WCW-1:0]  wcnt_reg;
    logic            out_valid_reg;
    logic            busy_reg;
    logic            overrun_reg;

    logic [CW:0]     sum_wide;
    logic [CW-1:0]   acc_next;

    // One bit of headroom lets the clamp detect overflow instead of wrapping.
    assign sum_wide = {1'b0, acc_reg} + {{CW{1'b0}}, spike_in};
    assign acc_next = (sum_wide > SAT_MAX) ? {CW{1'b1}} : sum_wide[CW-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            acc_reg       <= '0;
            rate_reg      <= '0;
            wcnt_reg      <= '0;
            out_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
            overrun_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        state_reg <= ACCUM;
                        acc_reg   <= '0;
                        wcnt_reg  <= '0;
                        busy_reg  <= 1'b1;
                    end
                end
                ACCUM: begin
                    if (start) begin
                        overrun_reg <= 1'b1;
                    end
                    acc_reg  <= acc_next;
                    wcnt_reg <= wcnt_reg + 1'b1;
                    if (wcnt_reg == LAST) begin
                        rate_reg      <= acc_next;
                        out_valid_reg <= 1'b1;
                        busy_reg      <= 1'b0;
                        state_reg     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        // A start coinciding with the handshake opens the next window immediately.
                        if (start) begin
                            state_reg <= ACCUM;
                            acc_reg   <= '0;
                            wcnt_reg  <= '0;
                            busy_reg  <= 1'b1;
                        end else begin
                            state_reg <= IDLE;
                        end
                    end else if (start) begin
                        overrun_reg <= 1'b1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign out_valid = out_valid_reg;
    assign rate      = rate_reg;
    assign busy      = busy_reg;
    assign overrun   = overrun_reg;

endmodule

// File: tb/tb_neuron_rate_decoder.sv
// Directed bench for neuron_rate_decoder: three configurations, scoreboard queues
// filled at window start and drained on each output handshake.
`timescale 1ns/1ps
module tb_neuron_rate_decoder;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic start0 = 1'b0;
    logic start_aux = 1'b0;
    logic spike_in = 1'b0;
    logic ready0 = 1'b1;
    logic ready_aux = 1'b1;

    logic       v0, b0, o0;
    logic [3:0] r0;
    logic       v1, b1, o1;
    logic [2:0] r1;
    logic       v2, b2, o2;
    logic [3:0] r2;

    int passed = 0;
    int total  = 0;
    int failed = 0;

    int q0[$];
    int q1[$];
    int q2[$];

    always #5 clk = ~clk;

    neuron_rate_decoder #(.WIN(15), .CW(4)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .spike_in(spike_in), .out_ready(ready0),
        .out_valid(v0), .rate(r0), .busy(b0), .overrun(o0));

    neuron_rate_decoder #(.WIN(15), .CW(3)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start_aux), .spike_in(spike_in), .out_ready(ready_aux),
        .out_valid(v1), .rate(r1), .busy(b1), .overrun(o1));

    neuron_rate_decoder #(.WIN(4), .CW(4)) u2 (
        .clk(clk), .rst_n(rst_n), .start(start_aux), .spike_in(spike_in), .out_ready(ready_aux),
        .out_valid(v2), .rate(r2), .busy(b2), .overrun(o2));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int model(input logic [14:0] pat, input int win, input int cw);
        int cnt = 0;
        for (int i = 0; i < win; i++) cnt += int'(pat[i]);
        if (cnt > (1 << cw) - 1) cnt = (1 << cw) - 1;
        return cnt;
    endfunction

    always @(negedge clk) begin
        if (rst_n && v0 && ready0) begin
            if (q0.size() == 0) check("u0_unexpected_result", 32'(r0), 32'hFFFF_FFFF);
            else check("u0_rate", 32'(r0), 32'(q0.pop_front()));
        end
    end

    always @(negedge clk) begin
        if (rst_n && v1 && ready_aux) begin
            if (q1.size() == 0) check("u1_unexpected_result", 32'(r1), 32'hFFFF_FFFF);
            else check("u1_rate", 32'(r1), 32'(q1.pop_front()));
        end
    end

    always @(negedge clk) begin
        if (rst_n && v2 && ready_aux) begin
            if (q2.size() == 0) check("u2_unexpected_result", 32'(r2), 32'hFFFF_FFFF);
            else check("u2_rate", 32'(r2), 32'(q2.pop_front()));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Feeds pat[0..14] on the 15 sample edges following an accepted start.
    task automatic feed(input logic [14:0] pat, input bit main);
        for (int i = 0; i < 15; i++) begin
            spike_in = pat[i];
            if (main) begin
                check("u0_busy_window", 32'(b0), 32'd1);
                if (i == 14) check("u0_valid_early", 32'(v0), 32'd0);
            end else begin
                if (i == 3) check("u2_valid_early", 32'(v2), 32'd0);
                if (i == 4) check("u2_valid_latency", 32'(v2), 32'd1);
            end
            step();
        end
        spike_in = 1'b0;
        if (main) begin
            check("u0_valid_latency", 32'(v0), 32'd1);
            check("u0_busy_done", 32'(b0), 32'd0);
        end else begin
            check("u1_valid_latency", 32'(v1), 32'd1);
        end
    endtask

    task automatic run_window(input logic [14:0] pat, input bit main);
        if (main) begin
            q0.push_back(model(pat, 15, 4));
            start0 = 1'b1;
        end else begin
            q1.push_back(model(pat, 15, 3));
            q2.push_back(model(pat, 4, 4));
            start_aux = 1'b1;
        end
        step();
        start0 = 1'b0;
        start_aux = 1'b0;
        feed(pat, main);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [14:0] pat_alt;
        logic [14:0] pat_bp;
        logic [14:0] pat_b2b;
        int exp_v;
        int bad;

        pat_alt = 15'b101010101010101;
        pat_bp  = 15'h1234;
        pat_b2b = 15'h7FFE;

        // Asynchronous reset before any clock edge
        #1 rst_n = 1'b0;
        #1;
        check("rst_u0_valid", 32'(v0), 32'd0);
        check("rst_u0_rate", 32'(r0), 32'd0);
        check("rst_u0_busy", 32'(b0), 32'd0);
        check("rst_u0_overrun", 32'(o0), 32'd0);
        check("rst_u1_all", {28'd0, v1, b1, o1, |r1}, 32'd0);
        check("rst_u2_all", {28'd0, v2, b2, o2, |r2}, 32'd0);
        step();
        step();
        rst_n = 1'b1;
        step();

        // Full window, all ones
        run_window(15'h7FFF, 1'b1);
        step();

        // Alternating pattern; rate must persist after the handshake
        run_window(pat_alt, 1'b1);
        step();
        step();
        check("u0_valid_cleared", 32'(v0), 32'd0);
        check("u0_rate_held", 32'(r0), 32'(model(pat_alt, 15, 4)));

        // All zeros
        run_window(15'h0000, 1'b1);
        step();

        // Backpressure with a dropped start, then back-to-back restart
        ready0 = 1'b0;
        run_window(pat_bp, 1'b1);
        exp_v = model(pat_bp, 15, 4);
        check("bp_overrun_before", 32'(o0), 32'd0);
        for (int h = 0; h < 5; h++) begin
            check("bp_valid_held", 32'(v0), 32'd1);
            check("bp_rate_held", 32'(r0), 32'(exp_v));
            if (h == 2) start0 = 1'b1;
            step();
            start0 = 1'b0;
        end
        check("bp_overrun_set", 32'(o0), 32'd1);
        check("bp_start_ignored", 32'(b0), 32'd0);
        q0.push_back(model(pat_b2b, 15, 4));
        start0 = 1'b1;
        ready0 = 1'b1;
        step();
        start0 = 1'b0;
        check("b2b_valid_dropped", 32'(v0), 32'd0);
        check("b2b_busy", 32'(b0), 32'd1);
        check("b2b_overrun_sticky", 32'(o0), 32'd1);
        feed(pat_b2b, 1'b1);
        step();

        // Saturation: CW=3 clamps, WIN=4 counts only four samples
        run_window(15'h7FFF, 1'b0);
        step();
        run_window(15'h01FF, 1'b0);
        step();
        run_window(15'h0005, 1'b0);
        step();
        check("u1_no_overrun", 32'(o1), 32'd0);

        // Reset in the middle of a window
        start0 = 1'b1;
        step();
        start0 = 1'b0;
        spike_in = 1'b1;
        repeat (6) step();
        #3 rst_n = 1'b0;
        #1;
        check("midrst_valid", 32'(v0), 32'd0);
        check("midrst_rate", 32'(r0), 32'd0);
        check("midrst_busy", 32'(b0), 32'd0);
        check("midrst_overrun", 32'(o0), 32'd0);
        step();
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (v0 !== 1'b0 || b0 !== 1'b0) bad++;
            step();
        end
        check("midrst_no_partial", 32'(bad), 32'd0);
        spike_in = 1'b0;
        run_window(15'h7FFF, 1'b1);
        step();
        step();

        check("q0_drained", 32'(q0.size()), 32'd0);
        check("q1_drained", 32'(q1.size()), 32'd0);
        check("q2_drained", 32'(q2.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
